// File: rtl/crc16_frame_checker.sv
// CRC-16/XMODEM frame checker: folds each accepted byte into the running CRC,
// counts frame length and reports residue/length status with a ready/valid handshake.
module crc16_frame_checker #(
  parameter int unsigned MAX_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_crc_ok,
  output logic        res_len_err,
  output logic [15:0] res_len
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

  // Eight MSB-first bit steps of poly 0x1021 for one byte.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  state_t      r_state;
  logic [15:0] r_crc;
  logic [15:0] r_len;
  logic        r_over;
  logic        r_in_ready;
  logic        r_res_valid;
  logic        r_res_crc_ok;
  logic        r_res_len_err;
  logic [15:0] r_res_len;

  logic        w_xfer;
  logic [15:0] w_crc_next;
  logic [15:0] w_len_next;
  logic        w_over_next;
  logic        w_len_err;

  assign w_xfer      = in_valid & r_in_ready;
  assign w_crc_next  = crc16_byte(r_crc, in_data);
  assign w_len_next  = (r_len == 16'hFFFF) ? r_len : (r_len + 16'd1);
  // Overlength is latched as a flag so a saturated counter still reports it.
  assign w_over_next = r_over | ({1'b0, r_len} >= MAX_LEN_W);
  assign w_len_err   = (w_len_next < 16'd3) | w_over_next;

  // Frame FSM with running CRC, length counter and registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_crc         <= 16'h0000;
      r_len         <= 16'h0000;
      r_over        <= 1'b0;
      r_in_ready    <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_crc_ok  <= 1'b0;
      r_res_len_err <= 1'b0;
      r_res_len     <= 16'h0000;
    end else begin
      case (r_state)
        IDLE, RECV: begin
          r_in_ready <= 1'b1;
          if (w_xfer) begin
            r_crc  <= w_crc_next;
            r_len  <= w_len_next;
            r_over <= w_over_next;
            if (in_last) begin
              r_state       <= REPORT;
              r_in_ready    <= 1'b0;
              r_res_valid   <= 1'b1;
              r_res_len     <= w_len_next;
              r_res_len_err <= w_len_err;
              r_res_crc_ok  <= (w_crc_next == 16'h0000) & ~w_len_err;
            end else begin
              r_state <= RECV;
            end
          end
        end
        REPORT: begin
          if (res_ready) begin
            r_state       <= IDLE;
            r_crc         <= 16'h0000;
            r_len         <= 16'h0000;
            r_over        <= 1'b0;
            r_in_ready    <= 1'b1;
            r_res_valid   <= 1'b0;
            r_res_crc_ok  <= 1'b0;
            r_res_len_err <= 1'b0;
            r_res_len     <= 16'h0000;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_crc         <= 16'h0000;
          r_len         <= 16'h0000;
          r_over        <= 1'b0;
          r_in_ready    <= 1'b0;
          r_res_valid   <= 1'b0;
          r_res_crc_ok  <= 1'b0;
          r_res_len_err <= 1'b0;
          r_res_len     <= 16'h0000;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign res_valid   = r_res_valid;
  assign res_crc_ok  = r_res_crc_ok;
  assign res_len_err = r_res_len_err;
  assign res_len     = r_res_len;

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Scoreboard bench for crc16_frame_checker: drives the default instance and a
// MAX_LEN=8 instance with identical stimulus and checks each against its own queue.
module tb_crc16_frame_checker;

  typedef struct packed {
    logic        ok;
    logic        err;
    logic [15:0] len;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        res_ready;
  logic        in_ready,  res_valid,  res_crc_ok,  res_len_err;
  logic [15:0] res_len;
  logic        in_ready8, res_valid8, res_crc_ok8, res_len_err8;
  logic [15:0] res_len8;

  exp_t       q[$];
  exp_t       q8[$];
  logic [7:0] frame_q[$];
  int         checks;
  int         errors;

  crc16_frame_checker dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_crc_ok(res_crc_ok), .res_len_err(res_len_err), .res_len(res_len)
  );

  crc16_frame_checker #(.MAX_LEN(8)) dut8 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready8), .res_valid(res_valid8), .res_ready(res_ready),
    .res_crc_ok(res_crc_ok8), .res_len_err(res_len_err8), .res_len(res_len8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_crc(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {d, 8'h00};
    for (int k = 0; k < 8; k++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic load_good(input logic [7:0] last_byte);
    frame_q.delete();
    for (int i = 0; i < 9; i++) frame_q.push_back(8'h31 + 8'(i));
    frame_q.push_back(8'h31);
    frame_q.push_back(last_byte);
  endtask

  task automatic load_random(input int payload_len);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'h0000;
    frame_q.delete();
    for (int i = 0; i < payload_len; i++) begin
      b = 8'($urandom_range(0, 255));
      frame_q.push_back(b);
      c = ref_crc(c, b);
    end
    frame_q.push_back(c[15:8]);
    frame_q.push_back(c[7:0]);
  endtask

  task automatic send_frame(input bit bubble, input bit crc_good);
    int   n;
    int   t;
    exp_t e;
    n = frame_q.size();
    e.len = (n > 65535) ? 16'hFFFF : 16'(n);
    e.err = (n < 3) || (n > 256);
    e.ok  = crc_good && !e.err;
    q.push_back(e);
    e.err = (n < 3) || (n > 8);
    e.ok  = crc_good && !e.err;
    q8.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (bubble && i > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hA5;
        in_last  = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame_q[i];
      in_last  = (i == n - 1);
      t = 0;
      while (!in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout byte=%0d got=%b want=1", i, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(input string name, input int hold);
    exp_t e, e8;
    logic [19:0] snap, snap8;
    checks++;
    if (res_valid !== 1'b1 || res_valid8 !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency res_valid=%b/%b want=1", name, res_valid, res_valid8);
    end
    checks++;
    if (q.size() == 0 || q8.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard_empty got=%0d want>0", name, q.size());
    end else begin
      e  = q.pop_front();
      e8 = q8.pop_front();
      if ({res_crc_ok, res_len_err, res_len} !== e) begin
        errors++;
        $display("FAIL %s_result got ok=%b err=%b len=%0d want ok=%b err=%b len=%0d",
                 name, res_crc_ok, res_len_err, res_len, e.ok, e.err, e.len);
      end
      checks++;
      if ({res_crc_ok8, res_len_err8, res_len8} !== e8) begin
        errors++;
        $display("FAIL %s_result_max8 got ok=%b err=%b len=%0d want ok=%b err=%b len=%0d",
                 name, res_crc_ok8, res_len_err8, res_len8, e8.ok, e8.err, e8.len);
      end
    end
    snap  = {res_valid, res_crc_ok, res_len_err, res_len, in_ready};
    snap8 = {res_valid8, res_crc_ok8, res_len_err8, res_len8, in_ready8};
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      checks++;
      if ({res_valid, res_crc_ok, res_len_err, res_len, in_ready} !== snap ||
          {res_valid8, res_crc_ok8, res_len_err8, res_len8, in_ready8} !== snap8 ||
          in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_hold cycle=%0d got=%h want=%h in_ready=%b want=0",
                 name, c, {res_valid, res_crc_ok, res_len_err, res_len, in_ready}, snap, in_ready);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || res_len !== 16'h0000 || res_crc_ok !== 1'b0 ||
        in_ready !== 1'b1 || res_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL %s_release got valid=%b len=%0d ready=%b want valid=0 len=0 ready=1",
               name, res_valid, res_len, in_ready);
    end
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk);
    #2 reset = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || res_valid !== 1'b0 || res_len !== 16'h0000 ||
        res_crc_ok !== 1'b0 || res_len_err !== 1'b0 || in_ready8 !== 1'b0) begin
      errors++;
      $display("FAIL %s_async got ready=%b valid=%b len=%0d want 0 0 0",
               name, in_ready, res_valid, res_len);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || in_ready8 !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_rise got ready=%b valid=%b want ready=1 valid=0",
               name, in_ready, res_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b0 || res_valid !== 1'b0 || res_crc_ok !== 1'b0 ||
        res_len_err !== 1'b0 || res_len !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state got ready=%b valid=%b ok=%b err=%b len=%0d want all 0",
               in_ready, res_valid, res_crc_ok, res_len_err, res_len);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_good_frame();
    load_good(8'hC3);
    send_frame(1'b0, 1'b1);
    get_result("good", 0);
  endtask

  task automatic test_corrupt_frame();
    load_good(8'hC2);
    send_frame(1'b0, 1'b0);
    get_result("corrupt", 0);
  endtask

  task automatic test_short_frames();
    frame_q = '{8'h00, 8'h00};
    send_frame(1'b0, 1'b1);
    get_result("short2", 0);
    frame_q = '{8'h31};
    send_frame(1'b0, 1'b0);
    get_result("short1", 0);
  endtask

  task automatic test_backpressure();
    load_good(8'hC3);
    send_frame(1'b0, 1'b1);
    get_result("backpressure", 5);
    load_good(8'hC3);
    send_frame(1'b0, 1'b1);
    get_result("after_backpressure", 0);
  endtask

  task automatic test_bubbles();
    load_good(8'hC3);
    send_frame(1'b1, 1'b1);
    get_result("bubbles", 0);
  endtask

  task automatic test_reset_mid_frame();
    load_good(8'hC3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame_q[i];
      in_last  = 1'b0;
    end
    pulse_reset("mid_frame");
    send_frame(1'b0, 1'b1);
    get_result("after_mid_frame_reset", 0);
    load_good(8'hC2);
    send_frame(1'b0, 1'b0);
    void'(q.pop_front());
    void'(q8.pop_front());
    pulse_reset("mid_report");
    load_good(8'hC3);
    send_frame(1'b0, 1'b1);
    get_result("after_mid_report_reset", 0);
  endtask

  task automatic test_length_boundary();
    load_random(254);
    send_frame(1'b0, 1'b1);
    get_result("len_max", 0);
    load_random(255);
    send_frame(1'b0, 1'b1);
    get_result("len_over", 0);
    load_random(5);
    send_frame(1'b1, 1'b1);
    get_result("random_small", 2);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    res_ready = 1'b0;
    test_reset();
    test_good_frame();
    test_corrupt_frame();
    test_short_frames();
    test_backpressure();
    test_bubbles();
    test_reset_mid_frame();
    test_length_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc16_frame_checker.md
CRC16_FRAME_CHECKER -- requirements
Module: crc16_frame_checker

Interface
REQ-001 SHALL have parameter MAX_LEN, default 256, maximum accepted frame length in bytes, CRC bytes included; legal range 3..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; asserted when 0, takes effect immediately regardless of clk.
REQ-004 SHALL have port in_data  input  8  received byte; payload bytes followed by the 2-byte CRC, MSB first.
REQ-005 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port in_last  input  1  qualifies in_data as the final byte of the frame; sampled only when in_valid=1.
REQ-007 SHALL have port in_ready  output  1  checker accepts a byte this cycle.
REQ-008 SHALL have port res_valid  output  1  frame result is presented on res_* outputs.
REQ-009 SHALL have port res_ready  input  1  consumer accepts the result this cycle.
REQ-010 SHALL have port res_crc_ok  output  1  1 = frame residue is zero and no length error.
REQ-011 SHALL have port res_len_err  output  1  frame shorter than 3 bytes or longer than MAX_LEN.
REQ-012 SHALL have port res_len  output  16  total bytes received in the frame, CRC bytes included, saturating at 16'hFFFF.

Function
REQ-013 SHALL compute CRC-16/XMODEM: poly 0x1021, init 0x0000, MSB-first, no reflection, no final XOR; 8 bit-steps per accepted byte, in one cycle.
REQ-014 SHALL judge a frame good when the running CRC over all frame bytes, CRC bytes included, equals 0x0000.
REQ-015 SHALL transfer a byte only on a cycle where in_valid=1 and in_ready=1; no other cycle changes the CRC or the length counter.
REQ-016 SHALL implement states IDLE, RECV and REPORT.
REQ-017 IDLE SHALL drive in_ready=1 and res_valid=0, and SHALL hold crc=0x0000 and len=0.
REQ-018 In IDLE, a transfer with in_last=0 SHALL fold the byte into the CRC, set len=1 and move to RECV.
REQ-019 In IDLE, a transfer with in_last=1 SHALL set len=1 and move to REPORT with a length error.
REQ-020 RECV SHALL drive in_ready=1; each transfer SHALL update the CRC and increment len (saturating).
REQ-021 In RECV, a transfer with in_last=1 SHALL move to REPORT.
REQ-022 REPORT SHALL drive in_ready=0 and res_valid=1, and SHALL hold res_* stable until res_ready=1.
REQ-023 On the cycle where res_valid=1 and res_ready=1, REPORT SHALL return to IDLE with crc and len cleared; a new byte is accepted no earlier than the next cycle.
REQ-024 The result SHALL be valid on the cycle after the in_last transfer: 1 cycle latency from in_last to res_valid.
REQ-025 res_len_err SHALL be 1 when final len <3 or len >MAX_LEN; res_crc_ok SHALL then be forced to 0.
REQ-026 On overlength (len exceeds MAX_LEN), the block SHALL keep accepting and counting bytes until in_last; it SHALL NOT abort early.
REQ-027 res_* outputs SHALL be registered; res_crc_ok, res_len_err and res_len SHALL be 0 whenever res_valid=0.
REQ-028 in_data and in_last SHALL be ignored on cycles without a transfer.

Reset
REQ-029 While reset=0: state=IDLE, crc=0x0000, len=0, in_ready=0, res_valid=0, res_crc_ok=0, res_len_err=0, res_len=0.
REQ-030 Assertion mid-frame or mid-REPORT SHALL discard the partial frame or pending result with no residual state.
REQ-031 in_ready SHALL rise on the first clk edge after reset deasserts.

Verification
REQ-032 Bench SHALL check the good frame: bytes "123456789", then 0x31, then 0xC3 with in_last -> res_valid next cycle, res_crc_ok=1, res_len_err=0, res_len=11.
REQ-033 Bench SHALL check a corrupted frame: same frame with final byte 0xC2 -> res_crc_ok=0, res_len_err=0, res_len=11.
REQ-034 Bench SHALL check short frames: a 2-byte frame 0x00, 0x00 -> res_len_err=1, res_crc_ok=0, res_len=2; a 1-byte frame -> res_len_err=1, res_len=1.
REQ-035 Bench SHALL check backpressure: hold res_ready=0 for 5 cycles after the REQ-032 frame -> res_* stable and in_ready=0 throughout; res_ready=1 -> IDLE the next cycle, and a following good frame passes.
REQ-036 Bench SHALL check bubbles: the REQ-032 frame with in_valid dropped every other cycle -> identical result to REQ-032.
REQ-037 Bench SHALL check reset mid-frame: pulse reset low after 4 bytes, then send the REQ-032 frame -> res_crc_ok=1, res_len=11; also MAX_LEN=8 with the REQ-032 frame -> res_len_err=1, res_len=11.
